// File: rtl/weight_load_sequencer.sv
// Sequencer for the input->hidden weight RAM: fills a staging array from an LFSR
// (or applies single host patches) and commits it with one write pulse plus a settle cycle.
module weight_load_sequencer #(
    parameter int          N_WEIGHTS   = 150,
    parameter int          WIDTH       = 10,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SCALE_SHIFT = 2
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  logic                         Start,
    input  logic                         HostWr,
    input  logic [7:0]                   HostAddr,
    input  logic [WIDTH-1:0]             HostData,
    output logic [WIDTH*N_WEIGHTS-1:0]   D,
    output logic                         WE,
    output logic                         Busy,
    output logic                         Done,
    output logic                         HostErr
);

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0]      SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam int               IDX_W    = $clog2(N_WEIGHTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WEIGHTS - 1);

    typedef enum logic [2:0] {IDLE, FILL, COMMIT, SETTLE, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [15:0]             lfsr;
    logic [15:0]             lfsr_next;
    logic [WIDTH-1:0]        staging [N_WEIGHTS];
    logic signed [9:0]       raw;
    logic signed [WIDTH-1:0] fill_w;

    // NOTE: combinational logic uses blocking '=' and assigns every output first,
    // so no latch can be inferred; the sequential block below uses '<=' only.
    always_comb begin
        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        raw       = lfsr_next[9:0];
        fill_w    = WIDTH'(raw >>> SCALE_SHIFT);
    end

    always_comb begin
        for (int i = 0; i < N_WEIGHTS; i++) begin
            D[i*WIDTH +: WIDTH] = staging[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state   <= IDLE;
            idx     <= '0;
            lfsr    <= SEED_EFF;
            WE      <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            HostErr <= 1'b0;
            // NOTE: the staging array is cleared on reset because it drives the RAM
            // data bus directly and must read back as all-zero afterwards.
            for (int i = 0; i < N_WEIGHTS; i++) begin
                staging[i] <= '0;
            end
        end else begin
            WE      <= 1'b0;
            Done    <= 1'b0;
            HostErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= FILL;
                        idx   <= '0;
                        Busy  <= 1'b1;
                    end else if (HostWr) begin
                        if (32'(HostAddr) < N_WEIGHTS) begin
                            staging[HostAddr] <= HostData;
                            state             <= COMMIT;
                            WE                <= 1'b1;
                            Busy              <= 1'b1;
                        end else begin
                            HostErr <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    lfsr         <= lfsr_next;
                    staging[idx] <= fill_w;
                    idx          <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                        WE    <= 1'b1;
                    end
                end
                COMMIT: state <= SETTLE;
                SETTLE: begin
                    state <= DONE;
                    Done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Bench for weight_load_sequencer: a timeline/array model predicts every output each cycle,
// and a default-seed and a zero-seed instance are both held to it.
module tb_weight_load_sequencer;

    localparam int N = 150;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           host_wr = 1'b0;
    logic [7:0]     host_addr = '0;
    logic [W-1:0]   host_data = '0;

    logic [W*N-1:0] d1, d0;
    logic           we1, busy1, done1, err1;
    logic           we0, busy0, done0, err0;

    always #5 clk = ~clk;

    weight_load_sequencer dut (
        .Clock(clk), .Rst(rst), .Start(start), .HostWr(host_wr),
        .HostAddr(host_addr), .HostData(host_data),
        .D(d1), .WE(we1), .Busy(busy1), .Done(done1), .HostErr(err1)
    );

    weight_load_sequencer #(.SEED(16'h0000)) dut_zero (
        .Clock(clk), .Rst(rst), .Start(start), .HostWr(host_wr),
        .HostAddr(host_addr), .HostData(host_data),
        .D(d0), .WE(we0), .Busy(busy0), .Done(done0), .HostErr(err0)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & 16'h002D), s[15:1]};
    endfunction

    function automatic logic [W-1:0] weight_of(input logic [15:0] s);
        int r;
        r = int'(s[9:0]);
        if (r >= 512) r -= 1024;
        return W'(r >>> 2);
    endfunction

    // Model: a command accepted at edge t with fill length L raises WE after edge t+L,
    // Done after t+L+2, Busy after edges t..t+L+2, and is idle again from edge t+L+4.
    logic [W-1:0] m_stage [N];
    logic [15:0]  m_lfsr = 16'hACE1;
    int           edge_n = 0;
    int           cmd_t = -1000;
    int           cmd_len = 0;
    int           next_free = 0;
    logic         e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    task automatic model_step();
        edge_n++;
        e_err = 1'b0;
        if (!rst) begin
            foreach (m_stage[i]) m_stage[i] = '0;
            m_lfsr    = 16'hACE1;
            cmd_t     = -1000;
            cmd_len   = 0;
            next_free = edge_n + 1;
        end else begin
            if (edge_n >= next_free) begin
                if (start) begin
                    cmd_t = edge_n; cmd_len = N; next_free = edge_n + N + 4;
                end else if (host_wr && host_addr < N) begin
                    m_stage[host_addr] = host_data;
                    cmd_t = edge_n; cmd_len = 0; next_free = edge_n + 4;
                end else if (host_wr) begin
                    e_err = 1'b1;
                end
            end
            if (cmd_len == N && edge_n > cmd_t && edge_n <= cmd_t + N) begin
                m_lfsr = lfsr_step(m_lfsr);
                m_stage[edge_n - cmd_t - 1] = weight_of(m_lfsr);
            end
        end
        e_we   = (edge_n == cmd_t + cmd_len);
        e_done = (edge_n == cmd_t + cmd_len + 2);
        e_busy = (edge_n >= cmd_t) && (edge_n <= cmd_t + cmd_len + 2);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // RAM behind the sequencer: captures D on each WE edge.
    logic [W-1:0] ram [N];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) ram[i] <= '0;
        end else if (we1) begin
            for (int i = 0; i < N; i++) ram[i] <= d1[i*W +: W];
        end
    end

    task automatic cmp(input string tag, input logic [W*N-1:0] d,
                       input logic we, input logic busy, input logic done, input logic err);
        int bad;
        bad = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (d[i*W +: W] !== m_stage[i]) bad = i;
        end
        check($sformatf("%s.D[%0d]", tag, bad), 32'(d[bad*W +: W]), 32'(m_stage[bad]));
        check({tag, ".WE"},      32'(we),   32'(e_we));
        check({tag, ".Busy"},    32'(busy), 32'(e_busy));
        check({tag, ".Done"},    32'(done), 32'(e_done));
        check({tag, ".HostErr"}, 32'(err),  32'(e_err));
    endtask

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("dflt", d1, we1, busy1, done1, err1);
            cmp("seed0", d0, we0, busy0, done0, err0);
            if (e_done) begin
                int bad;
                bad = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (ram[i] !== m_stage[i]) bad = i;
                end
                check($sformatf("ram_q[%0d]", bad), 32'(ram[bad]), 32'(m_stage[bad]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [W*N-1:0] first_set;

    initial begin
        tick(1);
        rst = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("reset_D_zero", 32'(d1 == '0), 32'd1);
        rst = 1'b1;
        tick(2);

        // First random fill with defaults.
        check("lfsr_pin", 32'(lfsr_step(16'hACE1)), 32'h5670);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(160);
        check("first_w_model", 32'(m_stage[0]), 32'h39C);
        check("first_w_dut", 32'(d1[9:0]), 32'h39C);
        first_set = d1;

        // Start held high: accepted at the first edge, ignored during FILL, re-accepted when idle.
        start = 1'b1;
        tick(155);
        start = 1'b0;
        tick(158);
        check("second_set_differs", 32'(d1 != first_set), 32'd1);

        // Valid patch.
        host_wr = 1'b1; host_addr = 8'd7; host_data = 10'h3FD;
        tick(1);
        host_wr = 1'b0;
        tick(5);
        check("patch7", 32'(d1[7*W +: W]), 32'h3FD);

        // Out-of-range patch.
        host_wr = 1'b1; host_addr = 8'd150; host_data = 10'h055;
        tick(1);
        host_wr = 1'b0;
        check("host_err_pulse", 32'(err1), 32'd1);
        check("host_err_not_busy", 32'(busy1), 32'd0);
        tick(3);

        // Start and HostWr together; HostWr held into FILL as well.
        start = 1'b1; host_wr = 1'b1; host_addr = 8'd3; host_data = 10'h005;
        tick(1);
        start = 1'b0;
        check("start_wins_no_err", 32'(err1), 32'd0);
        tick(2);
        host_wr = 1'b0;
        tick(160);

        // Reset in the middle of FILL (idx = 60), then a fresh Start repeats the first fill.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(60);
        rst = 1'b0;
        tick(1);
        check("midfill_rst_D_zero", 32'(d1 == '0), 32'd1);
        check("midfill_rst_busy", 32'(busy1), 32'd0);
        rst = 1'b1;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(160);
        check("refill_matches_first", 32'(d1 == first_set), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
